// File: rtl/cst_mask_refresh.sv
// rtl/cst_mask_refresh.sv - masked encoding and refresh of unmasked constants into a 2-entry output FIFO
//
// Purpose:
//   Turns an unmasked constant word into a d-share Boolean sharing.
//   For each constant bit, shares 0..d-2 take fresh randomness.
//   Share d-1 is the constant bit XORed with that randomness.
//   The shared word is registered and queued in a 2-entry FIFO for masked gadgets downstream.
//   There is no combinational path from cst_in or rnd to out.
//
// Parameters:
//   d      number of shares (>= 2)
//   count  constant bits per word
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cst_in     [count]        unmasked constant word
//   in_valid   cst_in valid
//   in_ready   block can accept a word (registered state and rst only)
//   rnd        [count*(d-1)]  fresh randomness, rnd[i*(d-1)+j] = sharing i, share j
//   rnd_valid  rnd valid
//   rnd_ready  rnd consumed this cycle (equals accept)
//   out        [count*d]      head entry, share j of bit i at out[i*d+j]
//   out_valid  FIFO holds at least one word
//   out_ready  consumer takes out this cycle
//
// Build option:
//   CST_MASK_REFRESH_CLEAR_EN  zero each vacated entry on pop; out reads 0 while empty
module cst_mask_refresh #(
   parameter int d     = 2,
   parameter int count = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [count-1:0]         cst_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [count*(d-1)-1:0]   rnd,
   input  logic                     rnd_valid,
   output logic                     rnd_ready,
   output logic [count*d-1:0]       out,
   output logic                     out_valid,
   input  logic                     out_ready
);

`ifdef CST_MASK_REFRESH_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [count*d-1:0]     head_q, head_d;
   logic [count*d-1:0]     tail_q, tail_d;
   logic [count*d-1:0]     enc;
   logic                   par;
   logic                   accept;
   logic                   pop;

   // in_ready depends on registered state and rst only, so a pop in FULL
   // never opens the input in the same cycle.
   assign in_ready  = (state_q != S_FULL) & ~rst;
   assign accept    = in_valid & rnd_valid & in_ready;
   assign rnd_ready = accept;
   assign out_valid = (state_q != S_EMPTY);
   assign pop       = out_valid & out_ready;
   assign out       = head_q;

   // Encode and refresh in one step: the fresh randomness fills the low
   // shares, and the top share absorbs the constant.
   always_comb begin
      enc = '0;
      par = 1'b0;
      for (int i = 0; i < count; i++) begin
         par = cst_in[i];
         for (int j = 0; j < d - 1; j++) begin
            enc[i*d + j] = rnd[i*(d-1) + j];
            par          = par ^ rnd[i*(d-1) + j];
         end
         enc[i*d + d - 1] = par;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         S_EMPTY: begin
            if (accept) begin
               head_d  = enc;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            if (accept && pop) begin
               // The head leaves and the new word replaces it directly.
               head_d = enc;
            end else if (accept) begin
               tail_d  = enc;
               state_d = S_FULL;
            end else if (pop) begin
               state_d = S_EMPTY;
               if (CLEAR_EN) head_d = '0;
            end
         end
         S_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = S_ONE;
               if (CLEAR_EN) tail_d = '0;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

endmodule
